// File: rtl/axi_default_wr_responder.sv
// Default AXI write slave for decode misses: sinks W bursts and answers each AW with one B.
// Optional WLAST_CHECK_EN: bursts whose WLAST placement disagrees with AWLEN return SLVERR.
module axi_default_wr_responder #(
  parameter int         ID_WIDTH      = 4,
  parameter int         PENDING_DEPTH = 4,
  parameter logic [1:0] DEFAULT_RESP  = 2'b11
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_WIDTH-1:0] AWID,
  input  logic [7:0]          AWLEN,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_WIDTH-1:0] BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY
);

  localparam int PTR_W = $clog2(PENDING_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(PENDING_DEPTH);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_DATA = 1'b1;

  // AW queue
  logic [ID_WIDTH-1:0] aw_id_mem  [PENDING_DEPTH];
  logic [7:0]          aw_len_mem [PENDING_DEPTH];
  logic [PTR_W-1:0]    aw_wr_ptr_reg;
  logic [PTR_W-1:0]    aw_rd_ptr_reg;
  logic [CNT_W-1:0]    aw_count_reg;
  logic                aw_push;
  logic                aw_pop;

  // B queue
  logic [ID_WIDTH-1:0] b_id_mem   [PENDING_DEPTH];
  logic [1:0]          b_resp_mem [PENDING_DEPTH];
  logic [PTR_W-1:0]    b_wr_ptr_reg;
  logic [PTR_W-1:0]    b_rd_ptr_reg;
  logic [CNT_W-1:0]    b_count_reg;
  logic                b_push;
  logic                b_pop;

  // W burst tracking
  logic [0:0] state_reg;
  logic [0:0] state_next;
  logic [7:0] len_reg;
  logic [7:0] beats_reg;
  logic       beat_fire;
  logic       final_beat;
  logic       burst_start;
  logic [1:0] burst_resp;

  assign AWREADY     = (aw_count_reg != FULL_COUNT);
  assign aw_push     = AWVALID & AWREADY;
  assign WREADY      = (state_reg == W_DATA);
  assign beat_fire   = WVALID & WREADY;
  assign final_beat  = beat_fire & (beats_reg == len_reg);
  assign aw_pop      = final_beat;
  assign b_push      = final_beat;
  // A full B queue holds off the next burst, which is what back-pressures W.
  assign burst_start = (state_reg == W_IDLE) && (aw_count_reg != '0) && (b_count_reg != FULL_COUNT);

  assign BVALID = (b_count_reg != '0);
  assign b_pop  = BVALID & BREADY;
  assign BID    = b_id_mem[b_rd_ptr_reg];
  assign BRESP  = b_resp_mem[b_rd_ptr_reg];

`ifdef WLAST_CHECK_EN
  logic err_reg;
  logic beat_err;

  assign beat_err = WLAST != (beats_reg == len_reg);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      err_reg <= 1'b0;
    end else if (burst_start) begin
      err_reg <= 1'b0;
    end else if (beat_fire && beat_err) begin
      err_reg <= 1'b1;
    end
  end

  // The final beat's own WLAST error must count, so fold it in combinationally.
  assign burst_resp = (err_reg | beat_err) ? 2'b10 : DEFAULT_RESP;
`else
  logic unused_wlast;
  assign unused_wlast = WLAST;
  assign burst_resp   = DEFAULT_RESP;
`endif

  always_ff @(posedge ACLK) begin
    if (aw_push) begin
      aw_id_mem[aw_wr_ptr_reg]  <= AWID;
      aw_len_mem[aw_wr_ptr_reg] <= AWLEN;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_wr_ptr_reg <= '0;
      aw_rd_ptr_reg <= '0;
      aw_count_reg  <= '0;
    end else begin
      if (aw_push) aw_wr_ptr_reg <= aw_wr_ptr_reg + PTR_W'(1);
      if (aw_pop)  aw_rd_ptr_reg <= aw_rd_ptr_reg + PTR_W'(1);
      case ({aw_push, aw_pop})
        2'b10:   aw_count_reg <= aw_count_reg + CNT_W'(1);
        2'b01:   aw_count_reg <= aw_count_reg - CNT_W'(1);
        default: aw_count_reg <= aw_count_reg;
      endcase
    end
  end

  // B storage is cleared on reset so BID/BRESP read as zero while idle.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < PENDING_DEPTH; i++) begin
        b_id_mem[i]   <= '0;
        b_resp_mem[i] <= '0;
      end
    end else if (b_push) begin
      b_id_mem[b_wr_ptr_reg]   <= aw_id_mem[aw_rd_ptr_reg];
      b_resp_mem[b_wr_ptr_reg] <= burst_resp;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      b_wr_ptr_reg <= '0;
      b_rd_ptr_reg <= '0;
      b_count_reg  <= '0;
    end else begin
      if (b_push) b_wr_ptr_reg <= b_wr_ptr_reg + PTR_W'(1);
      if (b_pop)  b_rd_ptr_reg <= b_rd_ptr_reg + PTR_W'(1);
      case ({b_push, b_pop})
        2'b10:   b_count_reg <= b_count_reg + CNT_W'(1);
        2'b01:   b_count_reg <= b_count_reg - CNT_W'(1);
        default: b_count_reg <= b_count_reg;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      W_IDLE:  if (burst_start) state_next = W_DATA;
      W_DATA:  if (final_beat)  state_next = W_IDLE;
      default: state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg <= W_IDLE;
      len_reg   <= '0;
      beats_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (burst_start) begin
        len_reg   <= aw_len_mem[aw_rd_ptr_reg];
        beats_reg <= '0;
      end else if (beat_fire) begin
        beats_reg <= beats_reg + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_default_wr_responder.sv
// Scoreboard bench for axi_default_wr_responder: AW stimulus queues expected B, a monitor checks B.
module tb_axi_default_wr_responder;

  logic       ACLK;
  logic       ARESET;
  logic [3:0] AWID;
  logic [7:0] AWLEN;
  logic       AWVALID;
  logic       AWREADY;
  logic       WLAST;
  logic       WVALID;
  logic       WREADY;
  logic [3:0] BID;
  logic [1:0] BRESP;
  logic       BVALID;
  logic       BREADY;

  logic [5:0] exp_q[$];
  logic [5:0] mon_e;
  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] lens [10] = '{8'd0, 8'd1, 8'd3, 8'd0, 8'd2, 8'd7, 8'd0, 8'd1, 8'd4, 8'd0};

  axi_default_wr_responder dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .AWID    (AWID),
    .AWLEN   (AWLEN),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WLAST   (WLAST),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BID     (BID),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout required handshake", name);
  endtask

  // Scoreboard monitor: sampled on the falling edge, a B handshake happens at the next rising edge.
  always @(negedge ACLK) begin
    if (!ARESET && BVALID && BREADY) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL b_unexpected: got BID=%0d BRESP=%0d required no response", BID, BRESP);
      end else begin
        mon_e = exp_q.pop_front();
        $display("B  id=%0d resp=%0d (expected id=%0d resp=%0d)", BID, BRESP, mon_e[5:2], mon_e[1:0]);
        check("b_id", {28'd0, BID}, {28'd0, mon_e[5:2]});
        check("b_resp", {30'd0, BRESP}, {30'd0, mon_e[1:0]});
      end
    end
  end

  task automatic send_aw(input logic [3:0] id, input logic [7:0] len, input logic [1:0] resp);
    int t;
    t = 0;
    AWID = id;
    AWLEN = len;
    AWVALID = 1'b1;
    while (!AWREADY && t < 300) begin
      @(negedge ACLK);
      t++;
    end
    if (!AWREADY) begin
      timeout_fail("aw_handshake");
    end else begin
      exp_q.push_back({id, resp});
      $display("AW id=%0d len=%0d expect resp=%0d", id, len, resp);
    end
    @(posedge ACLK);
    #1;
    AWVALID = 1'b0;
  endtask

  // bad_beat < 0: WLAST on the true last beat; otherwise WLAST only on beat bad_beat.
  task automatic send_w(input logic [7:0] len, input int bad_beat);
    int t;
    for (int b = 0; b <= int'(len); b++) begin
      WVALID = 1'b1;
      WLAST = (bad_beat < 0) ? (b == int'(len)) : (b == bad_beat);
      t = 0;
      while (!WREADY && t < 300) begin
        @(negedge ACLK);
        t++;
      end
      if (!WREADY) timeout_fail("w_handshake");
      @(posedge ACLK);
      #1;
    end
    WVALID = 1'b0;
    WLAST = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge ACLK);
      t++;
    end
    if (exp_q.size() != 0) timeout_fail("b_drain");
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    AWVALID = 1'b0;
    WVALID = 1'b0;
    WLAST = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    AWID = '0;
    AWLEN = '0;
    AWVALID = 1'b0;
    WLAST = 1'b0;
    WVALID = 1'b0;
    BREADY = 1'b1;
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    do_reset();

    // Reset values and single-beat latency
    @(negedge ACLK);
    check("rst_awready", {31'd0, AWREADY}, 32'd1);
    check("rst_wready", {31'd0, WREADY}, 32'd0);
    check("rst_bvalid", {31'd0, BVALID}, 32'd0);
    check("rst_bid", {28'd0, BID}, 32'd0);
    check("rst_bresp", {30'd0, BRESP}, 32'd0);
    send_aw(4'd3, 8'd0, 2'b11);
    @(negedge ACLK);
    check("wready_cycle1", {31'd0, WREADY}, 32'd0);
    @(negedge ACLK);
    check("wready_cycle2", {31'd0, WREADY}, 32'd1);
    send_w(8'd0, -1);
    check("bvalid_after_last", {31'd0, BVALID}, 32'd1);
    check("bid_after_last", {28'd0, BID}, 32'd3);
    check("bresp_after_last", {30'd0, BRESP}, 32'd3);
    @(posedge ACLK);
    #1;
    check("bvalid_cleared", {31'd0, BVALID}, 32'd0);

    // AW queue fill, B queue fill, B-full stall
    BREADY = 1'b0;
    for (int i = 1; i <= 4; i++) send_aw(4'(i), 8'd3, 2'b11);
    check("aw_full", {31'd0, AWREADY}, 32'd0);
    send_w(8'd3, -1);
    check("aw_pop_frees", {31'd0, AWREADY}, 32'd1);
    send_aw(4'd5, 8'd3, 2'b11);
    for (int i = 0; i < 3; i++) send_w(8'd3, -1);
    repeat (3) @(posedge ACLK);
    #1;
    check("b_full_wready", {31'd0, WREADY}, 32'd0);
    check("b_full_bvalid", {31'd0, BVALID}, 32'd1);
    check("b_full_bid_held", {28'd0, BID}, 32'd1);
    BREADY = 1'b1;
    @(posedge ACLK);
    #1;
    BREADY = 1'b0;
    check("b_pop_next_bid", {28'd0, BID}, 32'd2);
    send_w(8'd3, -1);
    BREADY = 1'b1;
    wait_drain();

    // Continuous traffic with pointer wrap
    fork
      begin
        for (int i = 0; i < 10; i++) send_aw(4'(i), lens[i], 2'b11);
      end
      begin
        for (int i = 0; i < 10; i++) send_w(lens[i], -1);
      end
    join
    wait_drain();

    // Reset in the middle of a burst
    BREADY = 1'b0;
    send_aw(4'd8, 8'd0, 2'b11);
    send_w(8'd0, -1);
    send_aw(4'd6, 8'd7, 2'b11);
    send_aw(4'd7, 8'd0, 2'b11);
    for (int b = 0; b < 2; b++) begin
      WVALID = 1'b1;
      WLAST = 1'b0;
      for (int t = 0; t < 300 && !WREADY; t++) @(negedge ACLK);
      @(posedge ACLK);
      #1;
    end
    check("mid_burst_wready", {31'd0, WREADY}, 32'd1);
    ARESET = 1'b1;
    exp_q.delete();
    @(posedge ACLK);
    #1;
    check("rst_mid_wready", {31'd0, WREADY}, 32'd0);
    check("rst_mid_bvalid", {31'd0, BVALID}, 32'd0);
    check("rst_mid_awready", {31'd0, AWREADY}, 32'd1);
    WVALID = 1'b0;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    BREADY = 1'b1;
    send_aw(4'd9, 8'd0, 2'b11);
    send_w(8'd0, -1);
    wait_drain();

    // Misplaced WLAST: flagged only when the check is built in
`ifdef WLAST_CHECK_EN
    send_aw(4'd10, 8'd3, 2'b10);
`else
    send_aw(4'd10, 8'd3, 2'b11);
`endif
    send_w(8'd3, 1);
    send_aw(4'd11, 8'd3, 2'b11);
    send_w(8'd3, -1);
    wait_drain();

    check("no_lost_responses", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_default_wr_responder.md
Name: axi_default_wr_responder

Overview:
- Default write slave on the crossbar's decode-miss port.
- Accepts AW requests and sinks their W bursts, then generates one B response per burst, in AW order, with a fixed response code (DECERR by default).
- It is the B-channel transmitter whose responses are queued by the master-side B FIFO.
- Supports up to PENDING_DEPTH outstanding write addresses and PENDING_DEPTH queued responses.

Parameters:
- ID_WIDTH, 4, width of AWID/BID.
- PENDING_DEPTH, 4, entries in the AW queue and in the B queue (power of 2, >=2).
- DEFAULT_RESP, 2'b11, BRESP returned for every well-formed burst.

Ports:
- ACLK  input  1  clock.
- ARESET  input  1  synchronous active-high reset.
- AWID  input  ID_WIDTH  write address ID.
- AWLEN  input  8  burst length minus 1.
- AWVALID  input  1  address valid.
- AWREADY  output  1  address accepted.
- WLAST  input  1  last beat marker (data/strobe not needed, not ported).
- WVALID  input  1  data valid.
- WREADY  output  1  data accepted.
- BID  output  ID_WIDTH  response ID.
- BRESP  output  2  response code.
- BVALID  output  1  response valid.
- BREADY  input  1  response accepted.

Behaviour:
- One clock: ACLK. Reset: ARESET, synchronous, active-high.
- Reset:
  - Both queues are emptied; occupancy counters are $clog2(PENDING_DEPTH)+1 bits wide, so the full depth is usable.
  - W FSM goes to W_IDLE and the beat counter is cleared.
  - Outputs after reset: AWREADY=1, WREADY=0, BVALID=0, BID=0, BRESP=0.
- AW queue:
  - AWREADY = (aw_count != PENDING_DEPTH), decoded from registered count only.
  - AWVALID&AWREADY pushes {AWID,AWLEN} at the tail.
  - Push and pop in the same cycle leave the count unchanged.
  - A pop in the same cycle does not raise AWREADY while full.
- W FSM states: W_IDLE and W_DATA.
  - W_IDLE -> W_DATA when aw_count!=0 and b_count!=PENDING_DEPTH. On this transition, load len=head AWLEN and beats=0.
  - In W_DATA, WREADY=1.
  - Each WVALID&WREADY beat increments beats (8-bit).
  - The final beat is the one with beats==len.
  - On the final beat: pop the AW queue, push {head AWID, resp} into the B queue, return to W_IDLE.
  - WREADY is 0 in W_IDLE, so there is one idle cycle between bursts.
  - Burst termination is by beat count only; WLAST never ends a burst.
  - In W_IDLE, WREADY=0 and W beats arriving without a queued AW stall.
- B queue:
  - BVALID = (b_count!=0); BID/BRESP come from the head entry.
  - BVALID&BREADY pops the head.
  - Once BVALID is asserted, BID/BRESP are held stable until the handshake.
  - Push and pop in the same cycle leave the count unchanged.
  - When the B queue is full, no new burst starts, which back-pressures W.
- Latency:
  - AW handshake at cycle 0: earliest WREADY at cycle 2 (queue write at 1, FSM enters W_DATA at 2).
  - Final W beat at cycle N: BVALID at cycle N+1.
- Wrap-around: queue pointers wrap modulo PENDING_DEPTH; ordering is strictly FIFO.
- Reset mid-burst:
  - Partial burst and all queued entries are discarded; no B is issued for them.
  - WREADY and BVALID are 0 from the cycle after ARESET is sampled.

Optional Feature:
- Macro: WLAST_CHECK_EN.
- Defined:
  - A per-burst error flag is set when any beat has WLAST != (beats==len).
  - A flagged burst returns BRESP=2'b10 (SLVERR) instead of DEFAULT_RESP.
  - The flag clears when the FSM enters W_DATA.
  - Burst length is still governed by AWLEN.
- Not defined: WLAST is ignored; every burst returns DEFAULT_RESP.

Test Plan:
- Reset, then AWID=3 AWLEN=0; WVALID=1 WLAST=1 -> WREADY 2 cycles after the AW handshake; BVALID next cycle with BID=3, BRESP=2'b11; with BREADY=1 it clears the following cycle.
- Four AWs (IDs 1,2,3,4, AWLEN=3) with BREADY=0 -> AWREADY=0 after the 4th. Sink 16 beats -> 4 B entries held. Pulse BREADY -> BIDs 1,2,3,4 in order. A 5th AW is accepted only after an AW pop.
- B queue full (BREADY=0, four bursts done), 5th AW queued -> WREADY stays 0. One B pop -> 5th burst starts; its B is issued after its 4 beats.
- Continuous AW/W/B traffic with BREADY=1 for 10 bursts, IDs 0..9 mod 16 -> pointers wrap, BID order matches AWID order, no lost or duplicate responses.
- ARESET asserted during beat 2 of AWLEN=7 with 2 AWs queued -> next cycle WREADY=0, BVALID=0, AWREADY=1; a new AWLEN=0 burst then completes normally.
- With WLAST_CHECK_EN: AWLEN=3 with WLAST on beat 1 -> BRESP=2'b10; the next AWLEN=3 burst with correct WLAST -> BRESP=2'b11.
